// File: rtl/fb_pkg.sv
// Framebuffer geometry constants and read-sequencer state type shared by the
// framebuffer read path.
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_DATAW  = 4;
    localparam int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_FULL = 2'd2
    } fb_rd_state_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register delay line with asynchronous reset; the output is the
// input delayed by DEPTH clock cycles.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/fb_line_reader.sv
// Read-side sequencer: on each linebuffer request, issues one line of
// framebuffer addresses and realigns the returned data with a valid strobe.
module fb_line_reader
    import fb_pkg::*;
#(
    parameter int LEN   = FB_WIDTH,
    parameter int LINES = FB_HEIGHT,
    parameter int DATAW = FB_DATAW,
    parameter int ADDRW = $clog2(LEN * LINES),
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             data_req,
    output logic [ADDRW-1:0] fb_addr,
    input  logic [DATAW-1:0] fb_data,
    output logic             en_out,
    output logic [DATAW-1:0] data_out,
    output logic             busy,
    output logic             line_done,
    output logic             overrun
);

    localparam int PIXW  = $clog2(LEN + 1);
    localparam int LINEW = $clog2(LINES + 1);

    localparam logic [PIXW-1:0]  PIX_LAST  = PIXW'(LEN - 1);
    localparam logic [LINEW-1:0] LINE_MAX  = LINEW'(LINES);
    localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(LEN * LINES - 1);

    fb_rd_state_t     state_reg, state_next;
    logic [ADDRW-1:0] addr_reg, addr_next;
    logic [PIXW-1:0]  pix_reg, pix_next;
    logic [LINEW-1:0] line_reg, line_next;
    logic             overrun_reg, overrun_next;
    logic             en_out_reg, line_done_reg;
    logic [DATAW-1:0] data_out_reg;

    logic             issue;
    logic             last_issue;
    logic [1:0]       pipe_q;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        pix_next     = pix_reg;
        line_next    = line_reg;
        overrun_next = overrun_reg;
        issue        = (state_reg == ST_READ);
        // An address presented during frame_start still drains, but never closes a line.
        last_issue   = issue && (pix_reg == PIX_LAST) && !frame_start;

        if (frame_start) begin
            addr_next    = '0;
            pix_next     = '0;
            line_next    = '0;
            overrun_next = 1'b0;
            state_next   = data_req ? ST_READ : ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (data_req && (line_reg < LINE_MAX)) state_next = ST_READ;
                end
                ST_READ: begin
                    addr_next = (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
                    if (data_req) overrun_next = 1'b1;
                    if (pix_reg == PIX_LAST) begin
                        pix_next   = '0;
                        line_next  = line_reg + 1'b1;
                        state_next = ((line_reg + 1'b1) == LINE_MAX) ? ST_FULL : ST_IDLE;
                    end else begin
                        pix_next = pix_reg + 1'b1;
                    end
                end
                ST_FULL: begin
                    state_next = ST_FULL;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            pix_reg     <= '0;
            line_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            pix_reg     <= pix_next;
            line_reg    <= line_next;
            overrun_reg <= overrun_next;
        end
    end

    // Bit 0 marks an issued address, bit 1 marks the final address of a line.
    delay_line #(
        .WIDTH (2),
        .DEPTH (LAT)
    ) u_issue_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({last_issue, issue}),
        .q   (pipe_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out_reg    <= 1'b0;
            line_done_reg <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            en_out_reg    <= pipe_q[0];
            line_done_reg <= pipe_q[1];
            if (pipe_q[0]) data_out_reg <= fb_data;
        end
    end

    assign fb_addr   = addr_reg;
    assign busy      = (state_reg == ST_READ);
    assign overrun   = overrun_reg;
    assign en_out    = en_out_reg;
    assign data_out  = data_out_reg;
    assign line_done = line_done_reg;

endmodule

// File: tb/tb_fb_line_reader.sv
// Self-checking bench for fb_line_reader with a small 4x3 framebuffer and a
// two-cycle BRAM model returning addr[3:0] as data.
module tb_fb_line_reader;

    localparam int LEN   = 4;
    localparam int LINES = 3;
    localparam int LAT   = 2;
    localparam int DATAW = 4;
    localparam int ADDRW = $clog2(LEN * LINES);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_start = 1'b0;
    logic             data_req = 1'b0;
    logic [ADDRW-1:0] fb_addr;
    logic [DATAW-1:0] fb_data;
    logic             en_out;
    logic [DATAW-1:0] data_out;
    logic             busy;
    logic             line_done;
    logic             overrun;

    typedef struct packed {
        logic [DATAW-1:0] d;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fb_line_reader #(
        .LEN   (LEN),
        .LINES (LINES),
        .DATAW (DATAW),
        .LAT   (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .data_req    (data_req),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .en_out      (en_out),
        .data_out    (data_out),
        .busy        (busy),
        .line_done   (line_done),
        .overrun     (overrun)
    );

    // BRAM model: data = addr[3:0], valid LAT cycles after the address.
    logic [DATAW-1:0] mem_pipe [LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= DATAW'(fb_addr);
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign fb_data = mem_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every en_out beat must match the next expected pixel.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_en_out", 32'(en_out), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("pixel data_out=%0d line_done=%0d (expect %0d/%0d)",
                             data_out, line_done, e.d, e.last);
                    check("data_out", 32'(data_out), 32'(e.d));
                    check("line_done", 32'(line_done), 32'(e.last));
                end
            end else if (line_done) begin
                check("line_done_without_en", 32'(line_done), 32'd0);
            end
        end
    end

    task automatic push_line(input int base, input int count);
        for (int i = 0; i < count; i++) begin
            exp_t e;
            e.d    = DATAW'(base + i);
            e.last = (i == LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    // Request one line (optionally together with frame_start, optionally with
    // an extra request at pixel req_at) and check the issued addresses.
    task automatic issue_line(input int base, input bit with_fs, input int req_at);
        data_req    = 1'b1;
        frame_start = with_fs;
        push_line(base, LEN);
        tick();
        data_req    = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            check("fb_addr", 32'(fb_addr), 32'(base + i));
            check("busy", 32'(busy), 32'd1);
            if (i == req_at) data_req = 1'b1;
            tick();
            data_req = 1'b0;
        end
        check("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int exp_addr [8] = '{0, 1, 2, 3, 4, 4, 4, 4};
    bit exp_busy [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit exp_en   [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    bit exp_ld   [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        // Reset state
        idle(2);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_en_out", 32'(en_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // First line: cycle-exact latency of addresses, busy, en_out, line_done
        data_req = 1'b1;
        push_line(0, LEN);
        tick();
        data_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("l0_fb_addr", 32'(fb_addr), 32'(exp_addr[c]));
            check("l0_busy", 32'(busy), 32'(exp_busy[c]));
            check("l0_en_out", 32'(en_out), 32'(exp_en[c]));
            check("l0_line_done", 32'(line_done), 32'(exp_ld[c]));
            tick();
        end

        // Lines 1 and 2, then the frame is full and the address wraps to 0
        idle(2);
        issue_line(4, 1'b0, -1);
        idle(6);
        issue_line(8, 1'b0, -1);
        idle(6);
        check("wrap_fb_addr", 32'(fb_addr), 32'd0);
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("full_busy", 32'(busy), 32'd0);
            check("full_fb_addr", 32'(fb_addr), 32'd0);
            check("full_overrun", 32'(overrun), 32'd0);
            tick();
        end

        // frame_start together with data_req while full
        issue_line(0, 1'b1, -1);
        idle(6);

        // Request while busy: line unaffected, overrun sticky
        check("pre_overrun", 32'(overrun), 32'd0);
        issue_line(4, 1'b0, 1);
        idle(6);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // frame_start aborts a line after two addresses; they still drain
        data_req = 1'b1;
        push_line(8, 2);
        tick();
        data_req = 1'b0;
        check("abort_addr0", 32'(fb_addr), 32'd8);
        tick();
        check("abort_addr1", 32'(fb_addr), 32'd9);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fb_addr", 32'(fb_addr), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        idle(6);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        issue_line(0, 1'b0, -1);
        idle(6);

        // Asynchronous reset mid-line: in-flight reads never appear
        check("pre_rst_queue", 32'(exp_q.size()), 32'd0);
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_fb_addr", 32'(fb_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_en_out", 32'(en_out), 32'd0);
        check("arst_data_out", 32'(data_out), 32'd0);
        check("arst_line_done", 32'(line_done), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        idle(8);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
